main_mem_ctrl: RTL and testbench
================================

# main_mem_ctrl

Memory-side responder for the cache-line fill/writeback interface of the brisc core. It accepts one full-line read or write request at a time from the cache miss handler, models a fixed main-memory latency with a countdown, and returns a line-wide response under a valid/ready handshake. It is the memory end of the cache interface and sits between the cache and the backing line store.

## Interface
- `MEM_LATENCY`, default 5: cycles in BUSY per request; must be ≥1.
- `MEM_LINES`, default 1024: number of lines in the store; must be a power of two.
- `clk` in 1: clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: responder can accept a request.
- `req_write_i` in 1: 1 = line write (writeback), 0 = line read (fill).
- `req_addr_i` in ADDRESS_BITS: byte address; offset bits [5:0] ignored.
- `req_wdata_i` in CACHE_LINE_LEN: write line data.
- `resp_valid_o` out 1: response present.
- `resp_ready_i` in 1: cache accepts response.
- `resp_rdata_o` out CACHE_LINE_LEN: read line data; all zeros for writes.
- `resp_err_o` out 1: out-of-range access; present only with `MAIN_MEM_ERR_EN`.

## Operation
- The FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - `req_ready_o`=1.
  - On `req_valid_i`, capture write flag, address and wdata, load `cnt`=MEM_LATENCY-1, and go to BUSY.
- BUSY:
  - `req_ready_o`=0.
  - If `cnt`≠0, decrement it.
  - If `cnt`=0, perform the access: a write commits the captured wdata to the store, and a read latches the line into the response register. Then go to RESP.
- RESP:
  - `resp_valid_o`=1.
  - `resp_rdata_o` and `resp_err_o` stay stable until `resp_valid_o && resp_ready_i`, then go to IDLE.
- Line index = `req_addr_i[6 +: log2(MEM_LINES)]`.
- Upper bits `[ADDRESS_BITS-1 : 6+log2(MEM_LINES)]` are out-of-range bits, handled per Configuration.
- Requests presented while `req_ready_o`=0 are ignored. The requester must hold them.
- Store contents are not reset. Only control state and outputs are reset.
- Reset has priority over every transition:
  - Reset during BUSY, including the final cycle, discards the request. A pending write is not committed.
  - Reset during RESP drops the response.
- Reset values:
  - `req_ready_o`=1 (IDLE).
  - `resp_valid_o`=0, `resp_rdata_o`=0, `resp_err_o`=0.
  - `cnt`=0.

## Timing
- Accept edge T = rising edge where `req_valid_i && req_ready_o`.
- BUSY occupies cycles T+1 … T+MEM_LATENCY.
- `resp_valid_o` rises in cycle T+MEM_LATENCY+1.
- With `resp_ready_i`=1, RESP lasts one cycle and IDLE returns at T+MEM_LATENCY+2.
- Throughput is at most one request per MEM_LATENCY+2 cycles. There is no request/response overlap.
- Read-after-write is coherent: a write commits before its response, so any later read returns the new data.
- Outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- Macro: `MAIN_MEM_ERR_EN`.
- Defined:
  - `resp_err_o` exists.
  - An access with any out-of-range bit set gets `resp_err_o`=1 in RESP.
  - A write with `resp_err_o`=1 does not modify the store.
  - A read with `resp_err_o`=1 returns all-zero `resp_rdata_o`.
  - Latency is unchanged.
- Undefined:
  - The port is absent.
  - Out-of-range bits are ignored, so addresses alias modulo MEM_LINES lines.

## Structure
- Add to `brisc_pkg`:
  - `MEM_LINE_OFFSET_BITS` = $clog2(CACHE_LINE_LEN/BYTE_LEN) (=6).
  - `typedef logic [CACHE_LINE_LEN-1:0] cache_line_t`.
  - `typedef enum logic [1:0] {MEM_IDLE, MEM_BUSY, MEM_RESP} mem_state_e`.
- Sub-module `mem_line_array`: MEM_LINES × cache_line_t storage with one synchronous write port (we, idx, wdata) and an asynchronous read port. Not reset.
- `main_mem_ctrl` holds the FSM, counter, capture registers and error decode.

## Test plan
- Reset: hold `reset` 2 cycles → `req_ready_o`=1, `resp_valid_o`=0, `resp_rdata_o`=0.
- Write/read, MEM_LATENCY=5:
  - Write addr 0x00001000, data {16{32'hDEADBEEF}}, accepted at T → `resp_valid_o` at T+6 with rdata=0.
  - Read 0x0000103C → rdata {16{32'hDEADBEEF}} at T'+6.
- Backpressure: read pending, `resp_ready_i` low 3 cycles → `resp_valid_o` and rdata stable for 4 cycles; IDLE the cycle after the handshake.
- Busy ignore: second request with different addr during BUSY → `req_ready_o`=0. The second request is accepted only after the first response completes, and returns its own data.
- Alias/error, MEM_LINES=1024: write 0x00010000 with pattern A, then read 0x00000000.
  - Without macro → returns A.
  - With macro → write gets `resp_err_o`=1, and the read returns the prior contents of line 0.
- Reset mid-BUSY: write 0x2000 with pattern B, assert `reset` at T+5 (final BUSY cycle) → no response. A subsequent read of 0x2000 returns the old data, not B.

Source files
------------

// File: rtl/brisc_pkg.sv
// -----------------------------------------------------------------------------
// brisc_pkg
//
// Shared types and constants for the brisc core's cache / main-memory path.
//
// Contents:
//   ADDRESS_BITS          - width of a byte address
//   BYTE_LEN              - bits per byte
//   CACHE_LINE_LEN        - bits per cache line
//   MEM_LINE_OFFSET_BITS  - byte-offset bits inside one line (=6)
//   cache_line_t          - one full cache line
//   mem_state_e           - main-memory responder FSM states
//   addrOutOfRange()      - true when any address bit above the line index is set
// -----------------------------------------------------------------------------
package brisc_pkg;

    localparam int ADDRESS_BITS         = 32;
    localparam int BYTE_LEN             = 8;
    localparam int CACHE_LINE_LEN       = 512;
    localparam int MEM_LINE_OFFSET_BITS = $clog2(CACHE_LINE_LEN / BYTE_LEN);

    typedef logic [CACHE_LINE_LEN-1:0] cache_line_t;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_BUSY,
        MEM_RESP
    } mem_state_e;

    // Everything above the line offset and the line index selects storage that
    // does not exist, so any set bit there marks the access as out of range.
    function automatic logic addrOutOfRange(input logic [ADDRESS_BITS-1:0] addr,
                                            input int idxBits);
        return |(addr >> (MEM_LINE_OFFSET_BITS + idxBits));
    endfunction

endpackage

// File: rtl/mem_line_array.sv
// -----------------------------------------------------------------------------
// mem_line_array
//
// Backing line store for the main-memory responder: MEM_LINES full cache
// lines, one synchronous write port and one asynchronous read port sharing a
// single line index. Contents are deliberately not reset.
//
// Ports:
//   clk      in  - clock, writes happen on the rising edge
//   we_i     in  - write enable
//   idx_i    in  - line index for both read and write
//   wdata_i  in  - line to write
//   rdata_o  out - line currently stored at idx_i (combinational)
// -----------------------------------------------------------------------------
module mem_line_array
    import brisc_pkg::*;
#(
    parameter int MEM_LINES = 1024,
    parameter int IDX_W     = $clog2(MEM_LINES)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  cache_line_t      wdata_i,
    output cache_line_t      rdata_o
);

    cache_line_t lines_q [MEM_LINES];

    // Single write port; no reset branch so the store keeps its contents
    // across a controller reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            lines_q[idx_i] <= wdata_i;
        end
    end

    // Asynchronous read lets the controller latch the line in the same edge
    // that ends the latency countdown.
    assign rdata_o = lines_q[idx_i];

endmodule

// File: rtl/main_mem_ctrl.sv
// -----------------------------------------------------------------------------
// main_mem_ctrl
//
// Memory-side responder for the brisc cache line fill / writeback interface.
// Accepts one full-line request at a time, holds it for MEM_LATENCY cycles to
// model main-memory latency, then returns a line-wide response under a
// valid/ready handshake.
//
// Optional feature macro: MAIN_MEM_ERR_EN
//   defined   - adds resp_err_o; addresses beyond the store are flagged, their
//               writes are dropped and their reads return zero.
//   undefined - no resp_err_o; upper address bits are ignored and addresses
//               alias modulo MEM_LINES lines.
//
// Parameters:
//   MEM_LATENCY - cycles spent in BUSY per request (>= 1)
//   MEM_LINES   - number of lines in the store (power of two)
//
// Ports:
//   clk           in  - clock
//   reset         in  - synchronous active-high reset
//   req_valid_i   in  - request present
//   req_ready_o   out - responder can accept a request
//   req_write_i   in  - 1 = line write, 0 = line read
//   req_addr_i    in  - byte address, low 6 bits ignored
//   req_wdata_i   in  - write line data
//   resp_valid_o  out - response present
//   resp_ready_i  in  - cache accepts response
//   resp_rdata_o  out - read line data, zero for writes
//   resp_err_o    out - out-of-range access (MAIN_MEM_ERR_EN only)
// -----------------------------------------------------------------------------
module main_mem_ctrl
    import brisc_pkg::*;
#(
    parameter int MEM_LATENCY = 5,
    parameter int MEM_LINES   = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDRESS_BITS-1:0] req_addr_i,
    input  cache_line_t             req_wdata_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output cache_line_t             resp_rdata_o
`ifdef MAIN_MEM_ERR_EN
    ,
    output logic                    resp_err_o
`endif
);

    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             write_q, write_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    cache_line_t      wdata_q, wdata_d;
    cache_line_t      rdata_q, rdata_d;

    logic             memWe;
    cache_line_t      memRdata;
    logic [IDX_W-1:0] reqIdx;

`ifdef MAIN_MEM_ERR_EN
    logic             oob_q, oob_d;
    logic             err_q, err_d;
    logic             reqOutOfRange;

    assign reqOutOfRange = addrOutOfRange(req_addr_i, IDX_W);
`else
    // High address bits only matter when errors are reported; without the
    // feature they simply alias, so the decode result is intentionally dropped.
    logic             unusedHighBits;

    assign unusedHighBits = addrOutOfRange(req_addr_i, IDX_W);
`endif

    assign reqIdx = req_addr_i[MEM_LINE_OFFSET_BITS +: IDX_W];

    mem_line_array #(
        .MEM_LINES (MEM_LINES),
        .IDX_W     (IDX_W)
    ) u_lines (
        .clk     (clk),
        .we_i    (memWe),
        .idx_i   (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (memRdata)
    );

    // Next-state logic: capture the request in IDLE, count down in BUSY and
    // perform the store access on the last BUSY cycle, then hold the response
    // in RESP until the cache takes it. The store write enable is masked by
    // reset so a reset on the final BUSY cycle never commits a write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        memWe   = 1'b0;
`ifdef MAIN_MEM_ERR_EN
        oob_d   = oob_q;
        err_d   = err_q;
`endif

        unique case (state_q)
            MEM_IDLE: begin
                if (req_valid_i) begin
                    write_d = req_write_i;
                    idx_d   = reqIdx;
                    wdata_d = req_wdata_i;
                    cnt_d   = CNT_LOAD;
`ifdef MAIN_MEM_ERR_EN
                    oob_d   = reqOutOfRange;
`endif
                    state_d = MEM_BUSY;
                end
            end

            MEM_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
`ifdef MAIN_MEM_ERR_EN
                    err_d   = oob_q;
                    memWe   = write_q && !oob_q && !reset;
                    rdata_d = (write_q || oob_q) ? '0 : memRdata;
`else
                    memWe   = write_q && !reset;
                    rdata_d = write_q ? '0 : memRdata;
`endif
                    state_d = MEM_RESP;
                end
            end

            MEM_RESP: begin
                if (resp_ready_i) begin
                    state_d = MEM_IDLE;
                end
            end

            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    // Control state and response registers; reset wins over every transition
    // and discards any request or response in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MEM_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef MAIN_MEM_ERR_EN
            oob_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef MAIN_MEM_ERR_EN
            oob_q   <= oob_d;
            err_q   <= err_d;
`endif
        end
    end

    // Handshake flags come straight from the state register, so no input
    // reaches an output combinationally.
    assign req_ready_o  = (state_q == MEM_IDLE);
    assign resp_valid_o = (state_q == MEM_RESP);
    assign resp_rdata_o = rdata_q;
`ifdef MAIN_MEM_ERR_EN
    assign resp_err_o   = err_q;
`endif

endmodule

// File: tb/tb_main_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_main_mem_ctrl
//
// Self-checking bench for main_mem_ctrl with default parameters
// (MEM_LATENCY=5, MEM_LINES=1024). Honours MAIN_MEM_ERR_EN the same way the
// design does. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_main_mem_ctrl;
    import brisc_pkg::*;

    localparam int MEM_LATENCY = 5;
    localparam int MEM_LINES   = 1024;
    localparam int WAIT_LIMIT  = 50;

    logic                    clk;
    logic                    reset;
    logic                    reqValid;
    logic                    reqReady;
    logic                    reqWrite;
    logic [ADDRESS_BITS-1:0] reqAddr;
    cache_line_t             reqWdata;
    logic                    respValid;
    logic                    respReady;
    cache_line_t             respRdata;
    logic                    respErr;

    int checks = 0;
    int errors = 0;

    main_mem_ctrl #(
        .MEM_LATENCY (MEM_LATENCY),
        .MEM_LINES   (MEM_LINES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (reqValid),
        .req_ready_o  (reqReady),
        .req_write_i  (reqWrite),
        .req_addr_i   (reqAddr),
        .req_wdata_i  (reqWdata),
        .resp_valid_o (respValid),
        .resp_ready_i (respReady),
        .resp_rdata_o (respRdata)
`ifdef MAIN_MEM_ERR_EN
        ,
        .resp_err_o   (respErr)
`endif
    );

`ifndef MAIN_MEM_ERR_EN
    assign respErr = 1'b0;
`endif

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic                    wr;
        logic [ADDRESS_BITS-1:0] addr;
        cache_line_t             wdata;
        cache_line_t             expRdata;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic wr,
                                 input logic [ADDRESS_BITS-1:0] addr,
                                 input cache_line_t wd);
        reqValid = valid;
        reqWrite = wr;
        reqAddr  = addr;
        reqWdata = wd;
    endtask

    // Called on the first falling edge after the accept edge; counts cycles
    // until resp_valid_o rises and checks req_ready_o stays low meanwhile.
    task automatic waitResponse(input string tag, output cache_line_t rdata,
                                output logic err);
        int lat;
        int busyReady;
        lat       = 1;
        busyReady = 0;
        while (respValid !== 1'b1 && lat < WAIT_LIMIT) begin
            if (reqReady !== 1'b0) busyReady++;
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, " latency"}, lat, MEM_LATENCY + 1);
        checkOutput({tag, " ready low while busy"}, busyReady, 0);
        rdata = respRdata;
        err   = respErr;
    endtask

    // Full request/response; holdCycles keeps resp_ready_i low that many
    // response cycles and checks the response holds steady meanwhile.
    task automatic runTransaction(input string tag, input logic wr,
                                  input logic [ADDRESS_BITS-1:0] addr,
                                  input cache_line_t wd, input int holdCycles,
                                  output cache_line_t rdata, output logic err);
        int waitCnt;
        int unstable;
        applyStimulus(1'b1, wr, addr, wd);
        respReady = (holdCycles == 0);
        waitCnt   = 0;
        while (reqReady !== 1'b1 && waitCnt < WAIT_LIMIT) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput({tag, " accepted"}, (waitCnt < WAIT_LIMIT), 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0);
        waitResponse(tag, rdata, err);
        if (holdCycles > 0) begin
            unstable = 0;
            for (int i = 0; i < holdCycles; i++) begin
                @(negedge clk);
                if (respValid !== 1'b1 || respRdata !== rdata || respErr !== err)
                    unstable++;
            end
            checkOutput({tag, " response stable under backpressure"}, unstable, 0);
            respReady = 1'b1;
        end
        @(negedge clk);
        checkOutput({tag, " idle after handshake"}, {reqReady, respValid}, 2'b10);
        respReady = 1'b0;
    endtask

    initial begin
        cache_line_t rd;
        logic        er;
        cache_line_t patDead, patOne, patA, patB, patC, patP0;
        int          spurious;

        patDead = {16{32'hDEADBEEF}};
        patOne  = {16{32'h12345678}};
        patA    = {16{32'hA5A50001}};
        patB    = {16{32'hB0B0B0B0}};
        patC    = {16{32'hC0DECAFE}};
        patP0   = {16{32'h0BADF00D}};

        vecs[0] = '{1'b1, 32'h0000_1000, patDead, '0};
        vecs[1] = '{1'b0, 32'h0000_103C, '0,      patDead};
        vecs[2] = '{1'b1, 32'h0000_1040, patOne,  '0};
        vecs[3] = '{1'b0, 32'h0000_1040, '0,      patOne};
        vecs[4] = '{1'b0, 32'h0000_1000, '0,      patDead};
        vecs[5] = '{1'b1, 32'h0000_2000, patC,    '0};
        vecs[6] = '{1'b0, 32'h0000_203F, '0,      patC};
        vecs[7] = '{1'b1, 32'h0000_0000, patP0,   '0};

        // Reset held for two cycles.
        reset     = 1'b1;
        respReady = 1'b0;
        applyStimulus(1'b0, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset req_ready", reqReady, 1'b1);
        checkOutput("reset resp_valid", respValid, 1'b0);
        checkOutput("reset resp_rdata", respRdata, '0);
`ifdef MAIN_MEM_ERR_EN
        checkOutput("reset resp_err", respErr, 1'b0);
`endif

        // Table-driven writes and reads.
        for (int i = 0; i < 8; i++) begin
            runTransaction($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr,
                           vecs[i].wdata, 0, rd, er);
            checkOutput($sformatf("vec%0d rdata", i), rd, vecs[i].expRdata);
`ifdef MAIN_MEM_ERR_EN
            checkOutput($sformatf("vec%0d err", i), er, 1'b0);
`endif
        end

        // Backpressure: resp_ready low for three response cycles.
        runTransaction("backpressure", 1'b0, 32'h0000_1000, '0, 3, rd, er);
        checkOutput("backpressure rdata", rd, patDead);

        // Second request held during BUSY must wait for the first response.
        respReady = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0000_1000, '0);
        checkOutput("busy-ignore first accept", reqReady, 1'b1);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 32'h0000_1040, '0);
        waitResponse("busy-ignore first", rd, er);
        checkOutput("busy-ignore first rdata", rd, patDead);
        @(negedge clk);
        checkOutput("busy-ignore idle before second", {reqReady, respValid}, 2'b10);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0);
        waitResponse("busy-ignore second", rd, er);
        checkOutput("busy-ignore second rdata", rd, patOne);
        @(negedge clk);
        checkOutput("busy-ignore idle after second", {reqReady, respValid}, 2'b10);
        respReady = 1'b0;

        // Alias / out-of-range: 0x00010000 maps onto line 0 when aliasing.
        runTransaction("alias write", 1'b1, 32'h0001_0000, patA, 0, rd, er);
        checkOutput("alias write rdata", rd, '0);
`ifdef MAIN_MEM_ERR_EN
        checkOutput("alias write err", er, 1'b1);
`endif
        runTransaction("alias read", 1'b0, 32'h0000_0000, '0, 0, rd, er);
`ifdef MAIN_MEM_ERR_EN
        checkOutput("alias read rdata", rd, patP0);
        checkOutput("alias read err", er, 1'b0);
`else
        checkOutput("alias read rdata", rd, patA);
`endif

        // Reset on the final BUSY cycle discards a pending write.
        applyStimulus(1'b1, 1'b1, 32'h0000_2000, patB);
        checkOutput("reset-busy accept", reqReady, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, '0, '0);
        repeat (MEM_LATENCY - 1) @(negedge clk);
        checkOutput("reset-busy still busy", {reqReady, respValid}, 2'b00);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset-busy state", {reqReady, respValid}, 2'b10);
        checkOutput("reset-busy rdata", respRdata, '0);
        spurious = 0;
        for (int i = 0; i < MEM_LATENCY + 2; i++) begin
            @(negedge clk);
            if (respValid !== 1'b0) spurious++;
        end
        checkOutput("reset-busy no response", spurious, 0);
        runTransaction("reset-busy read", 1'b0, 32'h0000_2000, '0, 0, rd, er);
        checkOutput("reset-busy read rdata", rd, patC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
